// File: rtl/savestate_pkg.sv
// Shared types and constants for the savestate request sequencer.
package savestate_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PAUSE  = 3'd1,
    ST_START  = 3'd2,
    ST_BUSY   = 3'd3,
    ST_ABORT  = 3'd4,
    ST_RESUME = 3'd5,
    ST_REPORT = 3'd6
  } state_e;

  // Engine operation
  typedef enum logic {
    OP_SAVE = 1'b0,
    OP_LOAD = 1'b1
  } op_e;

  // One queued request
  typedef struct packed {
    op_e        op;
    logic [1:0] slot;
  } req_t;

  // OSD info-text codes
  localparam logic [7:0] INFO_SLOT_BASE = 8'd10;
  localparam logic [7:0] INFO_TO_SAVE   = 8'd18;
  localparam logic [7:0] INFO_TO_LOAD   = 8'd19;
  localparam logic [7:0] INFO_EMPTY     = 8'd20;

  // Success code: 10 + {slot, is_load}
  function automatic logic [7:0] info_success(input logic [1:0] slot, input op_e op);
    return INFO_SLOT_BASE + {5'd0, slot, op};
  endfunction

endpackage

// File: rtl/savestate_sched_ss_req_queue.sv
// Request capture and priority pick: one manual pending slot (newest wins)
// plus a sticky auto-save flag. Manual requests are served before auto.
module ss_req_queue
  import savestate_pkg::*;
#(
  parameter logic [1:0] AUTO_SLOT = 2'd3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       allow_ss,
  input  logic       ui_save,
  input  logic       ui_load,
  input  logic [1:0] ui_slot,
  input  logic       auto_save,
  input  logic       pop,
  output logic       req_valid,
  output op_e        req_op,
  output logic [1:0] req_slot
);

  logic man_v_r;
  req_t man_r;
  logic auto_r;

  logic man_v_s;
  req_t man_s;
  logic auto_s;
  logic cap_ui_s;
  logic cap_auto_s;
  logic pop_man_s;
  logic pop_auto_s;

  // Next value of the pending entries; a capture in the same cycle as a pop wins
  always_comb begin
    man_v_s    = man_v_r;
    man_s      = man_r;
    auto_s     = auto_r;
    cap_ui_s   = allow_ss & (ui_save | ui_load);
    cap_auto_s = allow_ss & auto_save & ~auto_r;
    pop_man_s  = pop & man_v_r;
    pop_auto_s = pop & ~man_v_r & auto_r;
    if (cap_ui_s) begin
      man_v_s   = 1'b1;
      man_s.op  = ui_save ? OP_SAVE : OP_LOAD;
      man_s.slot = ui_slot;
    end else if (pop_man_s) begin
      man_v_s = 1'b0;
      man_s   = man_r;
    end else begin
      man_v_s = man_v_r;
      man_s   = man_r;
    end
    if (cap_auto_s) begin
      auto_s = 1'b1;
    end else if (pop_auto_s) begin
      auto_s = 1'b0;
    end else begin
      auto_s = auto_r;
    end
  end

  // Pending-entry registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      man_v_r <= 1'b0;
      man_r   <= '{op: OP_SAVE, slot: 2'd0};
      auto_r  <= 1'b0;
    end else begin
      man_v_r <= man_v_s;
      man_r   <= man_s;
      auto_r  <= auto_s;
    end
  end

  assign req_valid = man_v_r | auto_r;
  assign req_op    = man_v_r ? man_r.op : OP_SAVE;
  assign req_slot  = man_v_r ? man_r.slot : AUTO_SLOT;

endmodule

// File: rtl/savestate_sched.sv
// Savestate sequencer: arbitrates save/load requests, pauses the core,
// runs the engine under a watchdog, resumes the core and reports to the OSD.
module savestate_sched
  import savestate_pkg::*;
#(
  parameter int TIMEOUT_BITS = 24,
  parameter int ADDR_W       = 25,
  parameter int SLOT_SHIFT   = 20,
  parameter int AUTO_SLOT    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              allow_ss,
  input  logic              ui_save,
  input  logic              ui_load,
  input  logic [1:0]        ui_slot,
  input  logic              auto_save,
  input  logic [3:0]        slot_present,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic              ss_start,
  output logic              ss_load_mode,
  output logic [ADDR_W-1:0] ss_base_addr,
  input  logic              ss_done,
  output logic              ss_abort,
  output logic              busy,
  output logic              info_req,
  output logic [7:0]        info,
  output logic [3:0]        slot_valid
);

  localparam logic [TIMEOUT_BITS-1:0] CNT_ONE = TIMEOUT_BITS'(1);

  // Base address of a slot inside the savestate region
  function automatic logic [ADDR_W-1:0] slot_base(input logic [1:0] slot);
    logic [ADDR_W-1:0] base_s;
    base_s = ADDR_W'(slot);
    return base_s << SLOT_SHIFT;
  endfunction

  state_e                  state_r, state_s;
  logic                    pause_req_r, pause_req_s;
  logic                    ss_start_r, ss_start_s;
  logic                    ss_abort_r, ss_abort_s;
  logic                    info_req_r, info_req_s;
  logic [7:0]              info_r, info_s;
  op_e                     load_mode_r, load_mode_s;
  logic [1:0]              slot_r, slot_s;
  logic [ADDR_W-1:0]       base_addr_r, base_addr_s;
  logic [3:0]              valid_r, valid_s;
  logic                    failed_r, failed_s;
  logic [TIMEOUT_BITS-1:0] cnt_r, cnt_s;
  logic                    busy_r, busy_s;
  logic                    timeout_s;
  logic                    pop_s;
  logic                    req_valid_s;
  op_e                     req_op_s;
  logic [1:0]              req_slot_s;
  logic [3:0]              slot_valid_s;

  ss_req_queue #(
    .AUTO_SLOT (2'(AUTO_SLOT))
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .allow_ss  (allow_ss),
    .ui_save   (ui_save),
    .ui_load   (ui_load),
    .ui_slot   (ui_slot),
    .auto_save (auto_save),
    .pop       (pop_s),
    .req_valid (req_valid_s),
    .req_op    (req_op_s),
    .req_slot  (req_slot_s)
  );

  assign slot_valid_s = valid_r | slot_present;
  assign timeout_s    = cnt_r[TIMEOUT_BITS-1];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic; all outputs are registered below
  always_comb begin
    state_s     = state_r;
    pause_req_s = pause_req_r;
    ss_start_s  = 1'b0;
    ss_abort_s  = 1'b0;
    info_req_s  = 1'b0;
    info_s      = info_r;
    load_mode_s = load_mode_r;
    slot_s      = slot_r;
    base_addr_s = base_addr_r;
    valid_s     = valid_r;
    failed_s    = failed_r;
    cnt_s       = cnt_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (allow_ss && req_valid_s) begin
          pop_s = 1'b1;
          if ((req_op_s == OP_LOAD) && !slot_valid_s[req_slot_s]) begin
            // Nothing to load: report without disturbing the core
            info_req_s = 1'b1;
            info_s     = INFO_EMPTY;
          end else begin
            pause_req_s = 1'b1;
            cnt_s       = '0;
            load_mode_s = req_op_s;
            slot_s      = req_slot_s;
            base_addr_s = slot_base(req_slot_s);
            failed_s    = 1'b0;
            state_s     = ST_PAUSE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PAUSE: begin
        cnt_s = cnt_r + CNT_ONE;
        if (pause_ack) begin
          state_s = ST_START;
        end else if (timeout_s) begin
          ss_abort_s = 1'b1;
          failed_s   = 1'b1;
          state_s    = ST_ABORT;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_START: begin
        ss_start_s = 1'b1;
        cnt_s      = '0;
        state_s    = ST_BUSY;
      end
      ST_BUSY: begin
        cnt_s = cnt_r + CNT_ONE;
        // Completion takes precedence over a coincident timeout
        if (ss_done) begin
          if (load_mode_r == OP_SAVE) begin
            valid_s[slot_r] = 1'b1;
          end else begin
            valid_s = valid_r;
          end
          pause_req_s = 1'b0;
          state_s     = ST_RESUME;
        end else if (timeout_s) begin
          ss_abort_s = 1'b1;
          failed_s   = 1'b1;
          state_s    = ST_ABORT;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_ABORT: begin
        pause_req_s = 1'b0;
        state_s     = ST_RESUME;
      end
      ST_RESUME: begin
        if (!pause_ack) begin
          info_req_s = 1'b1;
          if (failed_r) begin
            info_s = (load_mode_r == OP_LOAD) ? INFO_TO_LOAD : INFO_TO_SAVE;
          end else begin
            info_s = info_success(slot_r, load_mode_r);
          end
          state_s = ST_REPORT;
        end else begin
          state_s = ST_RESUME;
        end
      end
      ST_REPORT: begin
        state_s = ST_IDLE;
      end
      default: begin
        pause_req_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Output, datapath and watchdog registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pause_req_r <= 1'b0;
      ss_start_r  <= 1'b0;
      ss_abort_r  <= 1'b0;
      info_req_r  <= 1'b0;
      info_r      <= 8'd0;
      load_mode_r <= OP_SAVE;
      slot_r      <= 2'd0;
      base_addr_r <= '0;
      valid_r     <= 4'd0;
      failed_r    <= 1'b0;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
    end else begin
      pause_req_r <= pause_req_s;
      ss_start_r  <= ss_start_s;
      ss_abort_r  <= ss_abort_s;
      info_req_r  <= info_req_s;
      info_r      <= info_s;
      load_mode_r <= load_mode_s;
      slot_r      <= slot_s;
      base_addr_r <= base_addr_s;
      valid_r     <= valid_s;
      failed_r    <= failed_s;
      cnt_r       <= cnt_s;
      busy_r      <= busy_s;
    end
  end

  assign pause_req    = pause_req_r;
  assign ss_start     = ss_start_r;
  assign ss_abort     = ss_abort_r;
  assign info_req     = info_req_r;
  assign info         = info_r;
  assign ss_load_mode = load_mode_r;
  assign ss_base_addr = base_addr_r;
  assign busy         = busy_r;
  assign slot_valid   = slot_valid_s;

endmodule

// File: tb/tb_savestate_sched.sv
// Directed bench for savestate_sched with a small core/engine model.
module tb_savestate_sched;

  logic        clk;
  logic        reset_n;
  logic        allow_ss;
  logic        ui_save;
  logic        ui_load;
  logic [1:0]  ui_slot;
  logic        auto_save;
  logic [3:0]  slot_present;
  logic        pause_req;
  logic        pause_ack;
  logic        ss_start;
  logic        ss_load_mode;
  logic [24:0] ss_base_addr;
  logic        ss_done;
  logic        ss_abort;
  logic        busy;
  logic        info_req;
  logic [7:0]  info;
  logic [3:0]  slot_valid;

  savestate_sched #(
    .TIMEOUT_BITS (8),
    .ADDR_W       (25),
    .SLOT_SHIFT   (20),
    .AUTO_SLOT    (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .allow_ss     (allow_ss),
    .ui_save      (ui_save),
    .ui_load      (ui_load),
    .ui_slot      (ui_slot),
    .auto_save    (auto_save),
    .slot_present (slot_present),
    .pause_req    (pause_req),
    .pause_ack    (pause_ack),
    .ss_start     (ss_start),
    .ss_load_mode (ss_load_mode),
    .ss_base_addr (ss_base_addr),
    .ss_done      (ss_done),
    .ss_abort     (ss_abort),
    .busy         (busy),
    .info_req     (info_req),
    .info         (info),
    .slot_valid   (slot_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event bookkeeping filled in by step()
  int          cyc = 0;
  int          n_start = 0;
  int          n_abort = 0;
  int          n_info = 0;
  int          start_cyc = 0;
  int          abort_cyc = 0;
  int          ack_rise_cyc = 0;
  logic        start_mode = 1'b0;
  logic [24:0] start_addr = 25'd0;
  logic [7:0]  last_info = 8'd0;
  logic        saw_pause = 1'b0;
  logic        ack_prev = 1'b0;
  logic        done_en = 1'b1;
  int          eng_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 ns after the edge, then drive the core/engine model
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ss_start) begin
      n_start++;
      start_cyc  = cyc;
      start_mode = ss_load_mode;
      start_addr = ss_base_addr;
    end
    if (ss_abort) begin
      n_abort++;
      abort_cyc = cyc;
    end
    if (info_req) begin
      n_info++;
      last_info = info;
    end
    if (pause_req) saw_pause = 1'b1;
    // Core acknowledges one cycle after the request changes
    if (ack_prev && !pause_ack) ack_rise_cyc = cyc;
    pause_ack = ack_prev;
    ack_prev  = pause_req;
    // Engine finishes three cycles after its start pulse
    ss_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) ss_done = 1'b1;
    end
    if (ss_start && done_en) eng_cnt = 3;
  endtask

  task automatic run_until_info(input int budget, output logic got, output int used);
    int base;
    base = n_info;
    got  = 1'b0;
    used = 0;
    while (!got && used < budget) begin
      step();
      used++;
      if (n_info != base) got = 1'b1;
    end
  endtask

  task automatic run_until_start(input int budget, output logic got);
    int base;
    int used;
    base = n_start;
    got  = 1'b0;
    used = 0;
    while (!got && used < budget) begin
      step();
      used++;
      if (n_start != base) got = 1'b1;
    end
  endtask

  task automatic pulse_ui(input logic sv, input logic ld, input logic [1:0] slot);
    ui_save = sv;
    ui_load = ld;
    ui_slot = slot;
    step();
    ui_save = 1'b0;
    ui_load = 1'b0;
  endtask

  initial begin
    logic got;
    int   used;
    int   s0;
    int   a0;

    reset_n      = 1'b0;
    allow_ss     = 1'b1;
    ui_save      = 1'b0;
    ui_load      = 1'b0;
    ui_slot      = 2'd0;
    auto_save    = 1'b0;
    slot_present = 4'b0000;
    pause_ack    = 1'b0;
    ss_done      = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_pause_req", 32'(pause_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_info", 32'(info), 32'd0);
    check("rst_base_addr", 32'(ss_base_addr), 32'd0);
    check("rst_slot_valid", 32'(slot_valid), 32'd0);
    reset_n = 1'b1;
    step();

    // 1: save to slot 2; pause_req rises two cycles after the request pulse
    pulse_ui(1'b1, 1'b0, 2'd2);
    check("s1_lat_c1", 32'(pause_req), 32'd0);
    step();
    check("s1_lat_c2", 32'(pause_req), 32'd1);
    run_until_info(60, got, used);
    check("s1_info_seen", 32'(got), 32'd1);
    check("s1_info", 32'(last_info), 32'd14);
    check("s1_starts", 32'(n_start), 32'd1);
    check("s1_start_after_ack", 32'(start_cyc - ack_rise_cyc), 32'd2);
    check("s1_mode", 32'(start_mode), 32'd0);
    check("s1_addr", 32'(start_addr), 32'h0020_0000);
    check("s1_pause_low", 32'(pause_req), 32'd0);
    check("s1_slot_valid", 32'(slot_valid), 32'b0100);
    step();
    check("s1_idle", 32'(busy), 32'd0);

    // 2: load from slot 2, then a rejected load from empty slot 1
    pulse_ui(1'b0, 1'b1, 2'd2);
    run_until_info(60, got, used);
    check("s2_info_seen", 32'(got), 32'd1);
    check("s2_info", 32'(last_info), 32'd15);
    check("s2_mode", 32'(start_mode), 32'd1);
    check("s2_pause_low", 32'(pause_req), 32'd0);
    check("s2_ack_low", 32'(pause_ack), 32'd0);
    step();
    saw_pause = 1'b0;
    pulse_ui(1'b0, 1'b1, 2'd1);
    run_until_info(10, got, used);
    check("s2_rej_seen", 32'(got), 32'd1);
    check("s2_rej_latency", 32'(used), 32'd1);
    check("s2_rej_info", 32'(last_info), 32'd20);
    repeat (3) step();
    check("s2_rej_no_pause", 32'(saw_pause), 32'd0);
    check("s2_rej_busy", 32'(busy), 32'd0);

    // 3: save to slot 1 with the engine silent -> watchdog abort.
    // Counter is 0 in the cycle ss_start is high, reaches 128 (bit 7) 128
    // cycles later, and the registered abort appears one cycle after that.
    done_en = 1'b0;
    a0 = n_abort;
    pulse_ui(1'b1, 1'b0, 2'd1);
    run_until_info(400, got, used);
    check("s3_info_seen", 32'(got), 32'd1);
    check("s3_aborts", 32'(n_abort - a0), 32'd1);
    check("s3_abort_delay", 32'(abort_cyc - start_cyc), 32'd129);
    check("s3_info", 32'(last_info), 32'd18);
    check("s3_slot_valid", 32'(slot_valid), 32'b0100);
    done_en = 1'b1;
    step();

    // 4: manual load queued behind an auto-save, both raised while busy
    slot_present = 4'b0001;
    pulse_ui(1'b1, 1'b0, 2'd2);
    run_until_start(20, got);
    check("s4_first_start", 32'(got), 32'd1);
    auto_save = 1'b1;
    step();
    auto_save = 1'b0;
    pulse_ui(1'b0, 1'b1, 2'd0);
    run_until_info(60, got, used);
    check("s4_first_info", 32'(last_info), 32'd14);
    run_until_info(60, got, used);
    check("s4_load_seen", 32'(got), 32'd1);
    check("s4_load_info", 32'(last_info), 32'd11);
    check("s4_load_addr", 32'(start_addr), 32'd0);
    run_until_info(60, got, used);
    check("s4_auto_seen", 32'(got), 32'd1);
    check("s4_auto_info", 32'(last_info), 32'd16);
    check("s4_auto_mode", 32'(start_mode), 32'd0);
    check("s4_auto_addr", 32'(start_addr), 32'h0030_0000);
    check("s4_slot_valid", 32'(slot_valid), 32'b1101);

    // 5: simultaneous save/load -> save wins; then requests blocked by allow_ss
    step();
    pulse_ui(1'b1, 1'b1, 2'd1);
    run_until_info(60, got, used);
    check("s5_info", 32'(last_info), 32'd12);
    check("s5_mode", 32'(start_mode), 32'd0);
    check("s5_slot_valid", 32'(slot_valid), 32'b1111);
    step();
    saw_pause = 1'b0;
    s0 = n_start;
    allow_ss = 1'b0;
    pulse_ui(1'b1, 1'b0, 2'd0);
    repeat (8) step();
    allow_ss = 1'b1;
    repeat (5) step();
    check("s5_blocked_pause", 32'(saw_pause), 32'd0);
    check("s5_blocked_start", 32'(n_start - s0), 32'd0);

    // 6: asynchronous reset while BUSY with an auto-save pending
    done_en = 1'b0;
    pulse_ui(1'b1, 1'b0, 2'd0);
    run_until_start(20, got);
    auto_save = 1'b1;
    step();
    auto_save = 1'b0;
    step();
    check("s6_busy_before", 32'(busy), 32'd1);
    check("s6_pause_before", 32'(pause_req), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("s6_async_pause", 32'(pause_req), 32'd0);
    check("s6_async_busy", 32'(busy), 32'd0);
    check("s6_async_info_req", 32'(info_req), 32'd0);
    ack_prev     = 1'b0;
    pause_ack    = 1'b0;
    eng_cnt      = 0;
    done_en      = 1'b1;
    slot_present = 4'b0000;
    step();
    reset_n   = 1'b1;
    saw_pause = 1'b0;
    repeat (10) step();
    check("s6_after_busy", 32'(busy), 32'd0);
    check("s6_after_no_pending", 32'(saw_pause), 32'd0);
    check("s6_after_valid", 32'(slot_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
